// File: rtl/csr_regfile.sv
// Machine-mode CSR file and trap sequencer for the RV64 pipeline (WB stage).
// Optional macro CSR_COUNTERS_EN adds the mcycle/minstret counters.
module csr_regfile #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            csr_we,
    input  logic [11:0]     csr_waddr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_rs1_data,
    input  logic [XLEN-1:0] csr_val_data,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            instr_retire,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
`endif

    // Clears bits [1:0] for 4-byte aligned mtvec/mepc.
    localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] wdata;
    logic            wr_en;

`ifdef CSR_COUNTERS_EN
    logic [XLEN-1:0] mcycle_q;
    logic [XLEN-1:0] minstret_q;
`else
    logic unused_retire;
    assign unused_retire = instr_retire;
`endif

    always_comb begin
        wdata = '0;
        case (csr_op)
            2'b01:   wdata = csr_rs1_data;
            2'b10:   wdata = csr_val_data | csr_rs1_data;
            2'b11:   wdata = csr_val_data & ~csr_rs1_data;
            default: wdata = '0;
        endcase
    end

    // Trap and mret both discard a same-cycle CSR write.
    assign wr_en = csr_we && (csr_op != 2'b00)
                && !trap_valid && !mret_valid;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_q;
    end

    always_comb begin
        csr_rdata   = '0;
        csr_illegal = 1'b0;
        case (csr_raddr)
            A_MSTATUS:  csr_rdata = mstatus_rd;
            A_MTVEC:    csr_rdata = mtvec_q;
            A_MSCRATCH: csr_rdata = mscratch_q;
            A_MEPC:     csr_rdata = mepc_q;
            A_MCAUSE:   csr_rdata = mcause_q;
            A_MTVAL:    csr_rdata = mtval_q;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:   csr_rdata = mcycle_q;
            A_MINSTRET: csr_rdata = minstret_q;
`endif
            default:    csr_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q          <= 1'b0;
            mpie_q         <= 1'b0;
            mtvec_q        <= MTVEC_RST & ALIGN;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= trap_valid | mret_valid;
            if (trap_valid) begin
                mepc_q      <= trap_pc & ALIGN;
                mcause_q    <= trap_cause;
                mtval_q     <= trap_tval;
                mpie_q      <= mie_q;
                mie_q       <= 1'b0;
                redirect_pc <= mtvec_q;
            end else if (mret_valid) begin
                mie_q       <= mpie_q;
                mpie_q      <= 1'b1;
                redirect_pc <= mepc_q;
            end else if (wr_en) begin
                case (csr_waddr)
                    A_MSTATUS: begin
                        mie_q  <= wdata[3];
                        mpie_q <= wdata[7];
                    end
                    A_MTVEC:    mtvec_q    <= wdata & ALIGN;
                    A_MSCRATCH: mscratch_q <= wdata;
                    A_MEPC:     mepc_q     <= wdata & ALIGN;
                    A_MCAUSE:   mcause_q   <= wdata;
                    A_MTVAL:    mtval_q    <= wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // A software write replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_en && csr_waddr == A_MCYCLE)
                mcycle_q <= wdata;
            else
                mcycle_q <= mcycle_q + XLEN'(1);
            if (wr_en && csr_waddr == A_MINSTRET)
                minstret_q <= wdata;
            else if (instr_retire)
                minstret_q <= minstret_q + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile.
// Directed scenarios plus randomized traffic against a reference model.
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [1:0]  csr_op;
    logic [63:0] csr_rs1_data;
    logic [63:0] csr_val_data;
    logic        trap_valid;
    logic [63:0] trap_cause;
    logic [63:0] trap_pc;
    logic [63:0] trap_tval;
    logic        mret_valid;
    logic        instr_retire;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    csr_regfile #(.XLEN(64), .MTVEC_RST(64'h0)) dut (
        .clk(clk), .rst(rst),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_op(csr_op),
        .csr_rs1_data(csr_rs1_data), .csr_val_data(csr_val_data),
        .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .instr_retire(instr_retire),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Reference model: architectural CSR values.
    bit          m_mie, m_mpie;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    bit          m_rv;
    logic [63:0] m_rpc;

    logic [11:0] addr_tab [8] = '{12'h300, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h301, 12'h7C0};

    function automatic logic [64:0] mread(input logic [11:0] a);
        logic [63:0] ms;
        ms = 64'h1800 + (m_mie ? 64'd8 : 64'd0) + (m_mpie ? 64'd128 : 64'd0);
        case (a)
            12'h300: return {1'b0, ms};
            12'h305: return {1'b0, m_mtvec};
            12'h340: return {1'b0, m_mscratch};
            12'h341: return {1'b0, m_mepc};
            12'h342: return {1'b0, m_mcause};
            12'h343: return {1'b0, m_mtval};
            default: return {1'b1, 64'h0};
        endcase
    endfunction

    task automatic model_step();
        logic [63:0] nv;
        bit          old_mie;
        if (rst) begin
            m_mie = 0; m_mpie = 0;
            m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
            m_mcause = 0; m_mtval = 0;
            m_rv = 0; m_rpc = 0;
        end else if (trap_valid) begin
            m_rv = 1; m_rpc = m_mtvec;
            m_mepc = trap_pc - (trap_pc % 4);
            m_mcause = trap_cause;
            m_mtval = trap_tval;
            m_mpie = m_mie; m_mie = 0;
        end else if (mret_valid) begin
            m_rv = 1; m_rpc = m_mepc;
            old_mie = m_mpie;
            m_mie = old_mie; m_mpie = 1;
        end else begin
            m_rv = 0;
            if (csr_we && csr_op != 2'b00) begin
                if (csr_op == 2'b01)      nv = csr_rs1_data;
                else if (csr_op == 2'b10) nv = csr_val_data | csr_rs1_data;
                else                      nv = csr_val_data & ~csr_rs1_data;
                case (csr_waddr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec = nv - (nv % 4);
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv - (nv % 4);
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; csr_we = 0; csr_waddr = 0; csr_op = 0;
        csr_rs1_data = 0; csr_val_data = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
        mret_valid = 0; instr_retire = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op,
                      input logic [63:0] val, input logic [63:0] rs1);
        csr_we = 1; csr_waddr = a; csr_op = op;
        csr_val_data = val; csr_rs1_data = rs1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        csr_raddr = 12'h300;
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        n_checks++;
        if (csr_rdata !== 64'h1800 || csr_illegal !== 1'b0)
            $display("FAIL reset_mstatus got %h/%b want 1800/0", csr_rdata, csr_illegal);
        else n_pass++;
        csr_raddr = 12'h7C0; #1;
        n_checks++;
        if (csr_rdata !== 64'h0 || csr_illegal !== 1'b1)
            $display("FAIL reset_illegal got %h/%b want 0/1", csr_rdata, csr_illegal);
        else n_pass++;
        csr_raddr = 12'h305; #1;
        n_checks++;
        if (csr_rdata !== 64'h0)
            $display("FAIL reset_mtvec got %h want 0", csr_rdata);
        else n_pass++;
        n_checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 64'h0)
            $display("FAIL reset_redirect got %b/%h want 0/0", redirect_valid, redirect_pc);
        else n_pass++;
    endtask

    task automatic test_rw_ops();
        wr(12'h305, 2'b01, 64'h0, 64'h8000_0103);
        csr_raddr = 12'h305; #1;
        n_checks++;
        if (csr_rdata !== 64'h8000_0100)
            $display("FAIL rw_mtvec got %h want 80000100", csr_rdata);
        else n_pass++;
        wr(12'h340, 2'b10, 64'hF0, 64'h0F);
        csr_raddr = 12'h340; #1;
        n_checks++;
        if (csr_rdata !== 64'hFF)
            $display("FAIL rs_mscratch got %h want ff", csr_rdata);
        else n_pass++;
        wr(12'h340, 2'b11, 64'hFF, 64'h0F);
        #1;
        n_checks++;
        if (csr_rdata !== 64'hF0)
            $display("FAIL rc_mscratch got %h want f0", csr_rdata);
        else n_pass++;
        wr(12'h340, 2'b00, 64'h0, 64'h1234);
        #1;
        n_checks++;
        if (csr_rdata !== 64'hF0)
            $display("FAIL op00_nowrite got %h want f0", csr_rdata);
        else n_pass++;
    endtask

    task automatic test_trap();
        wr(12'h300, 2'b01, 64'h0, 64'h8);
        csr_raddr = 12'h300; #1;
        n_checks++;
        if (csr_rdata !== 64'h1808)
            $display("FAIL set_mie got %h want 1808", csr_rdata);
        else n_pass++;
        trap_valid = 1; trap_pc = 64'h8000_0044;
        trap_cause = 64'd11; trap_tval = 64'h0;
        tick();
        idle();
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100)
            $display("FAIL trap_redirect got %b/%h want 1/80000100", redirect_valid, redirect_pc);
        else n_pass++;
        csr_raddr = 12'h341; #1;
        n_checks++;
        if (csr_rdata !== 64'h8000_0044)
            $display("FAIL trap_mepc got %h want 80000044", csr_rdata);
        else n_pass++;
        csr_raddr = 12'h342; #1;
        n_checks++;
        if (csr_rdata !== 64'd11)
            $display("FAIL trap_mcause got %h want b", csr_rdata);
        else n_pass++;
        csr_raddr = 12'h300; #1;
        n_checks++;
        if (csr_rdata !== 64'h1880)
            $display("FAIL trap_mstatus got %h want 1880", csr_rdata);
        else n_pass++;
    endtask

    task automatic test_mret();
        mret_valid = 1;
        tick();
        idle();
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0044)
            $display("FAIL mret_redirect got %b/%h want 1/80000044", redirect_valid, redirect_pc);
        else n_pass++;
        csr_raddr = 12'h300; #1;
        n_checks++;
        if (csr_rdata !== 64'h1888)
            $display("FAIL mret_mstatus got %h want 1888", csr_rdata);
        else n_pass++;
        tick();
        n_checks++;
        if (redirect_valid !== 1'b0)
            $display("FAIL redirect_pulse got %b want 0", redirect_valid);
        else n_pass++;
    endtask

    task automatic test_priority();
        trap_valid = 1; trap_pc = 64'h203; trap_cause = 64'd7;
        trap_tval = 64'hABC;
        mret_valid = 1;
        csr_we = 1; csr_waddr = 12'h340; csr_op = 2'b01;
        csr_rs1_data = 64'h123;
        tick();
        idle();
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100)
            $display("FAIL prio_redirect got %b/%h want 1/80000100", redirect_valid, redirect_pc);
        else n_pass++;
        csr_raddr = 12'h340; #1;
        n_checks++;
        if (csr_rdata !== 64'hF0)
            $display("FAIL prio_mscratch got %h want f0", csr_rdata);
        else n_pass++;
        csr_raddr = 12'h300; #1;
        n_checks++;
        if (csr_rdata !== 64'h1880)
            $display("FAIL prio_mstatus got %h want 1880", csr_rdata);
        else n_pass++;
        csr_raddr = 12'h341; #1;
        n_checks++;
        if (csr_rdata !== 64'h200)
            $display("FAIL prio_mepc got %h want 200", csr_rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rst = 1; trap_valid = 1; trap_pc = 64'h40;
        csr_we = 1; csr_waddr = 12'h340; csr_op = 2'b01;
        csr_rs1_data = 64'h55;
        tick();
        idle();
        n_checks++;
        if (redirect_valid !== 1'b0)
            $display("FAIL rstmid_redirect got %b want 0", redirect_valid);
        else n_pass++;
        csr_raddr = 12'h340; #1;
        n_checks++;
        if (csr_rdata !== 64'h0)
            $display("FAIL rstmid_mscratch got %h want 0", csr_rdata);
        else n_pass++;
        csr_raddr = 12'h305; #1;
        n_checks++;
        if (csr_rdata !== 64'h0)
            $display("FAIL rstmid_mtvec got %h want 0", csr_rdata);
        else n_pass++;
        tick();
        n_checks++;
        if (redirect_valid !== 1'b0)
            $display("FAIL rstmid_after got %b want 0", redirect_valid);
        else n_pass++;
    endtask

    task automatic test_counters();
`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 2'b01, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_raddr = 12'hB00; #1;
        n_checks++;
        if (csr_rdata !== 64'hFFFF_FFFF_FFFF_FFFF || csr_illegal !== 1'b0)
            $display("FAIL mcycle_load got %h/%b want ffffffffffffffff/0", csr_rdata, csr_illegal);
        else n_pass++;
        tick();
        n_checks++;
        if (csr_rdata !== 64'h0)
            $display("FAIL mcycle_wrap got %h want 0", csr_rdata);
        else n_pass++;
        tick();
        n_checks++;
        if (csr_rdata !== 64'h1)
            $display("FAIL mcycle_inc got %h want 1", csr_rdata);
        else n_pass++;
        instr_retire = 1;
        wr(12'hB02, 2'b01, 64'h0, 64'h0);
        instr_retire = 1;
        for (int i = 0; i < 3; i++) tick();
        idle();
        tick();
        csr_raddr = 12'hB02; #1;
        n_checks++;
        if (csr_rdata !== 64'd3 || csr_illegal !== 1'b0)
            $display("FAIL minstret got %h/%b want 3/0", csr_rdata, csr_illegal);
        else n_pass++;
`else
        instr_retire = 1;
        wr(12'hB00, 2'b01, 64'h0, 64'h5);
        csr_raddr = 12'hB00; #1;
        n_checks++;
        if (csr_rdata !== 64'h0 || csr_illegal !== 1'b1)
            $display("FAIL mcycle_absent got %h/%b want 0/1", csr_rdata, csr_illegal);
        else n_pass++;
        csr_raddr = 12'hB02; #1;
        n_checks++;
        if (csr_rdata !== 64'h0 || csr_illegal !== 1'b1)
            $display("FAIL minstret_absent got %h/%b want 0/1", csr_rdata, csr_illegal);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [64:0] exp;
        idle();
        rst = 1;
        tick();
        idle();
        for (int it = 0; it < 300; it++) begin
            csr_we       = ($urandom_range(0, 3) != 0);
            csr_op       = 2'($urandom_range(0, 3));
            csr_waddr    = addr_tab[$urandom_range(0, 7)];
            csr_rs1_data = {$urandom(), $urandom()};
            csr_val_data = {$urandom(), $urandom()};
            trap_valid   = ($urandom_range(0, 7) == 0);
            mret_valid   = ($urandom_range(0, 7) == 0);
            trap_pc      = {$urandom(), $urandom()};
            trap_cause   = {$urandom(), $urandom()};
            trap_tval    = {$urandom(), $urandom()};
            instr_retire = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 63) == 0);
            tick();
            n_checks++;
            if (redirect_valid !== m_rv)
                $display("FAIL rnd_rv it=%0d got %b want %b", it, redirect_valid, m_rv);
            else n_pass++;
            if (m_rv) begin
                n_checks++;
                if (redirect_pc !== m_rpc)
                    $display("FAIL rnd_rpc it=%0d got %h want %h", it, redirect_pc, m_rpc);
                else n_pass++;
            end
            for (int k = 0; k < 8; k++) begin
                csr_raddr = addr_tab[k];
                #1;
                exp = mread(addr_tab[k]);
                n_checks++;
                if (csr_rdata !== exp[63:0] || csr_illegal !== exp[64])
                    $display("FAIL rnd_read it=%0d addr=%h got %h/%b want %h/%b",
                             it, addr_tab[k], csr_rdata, csr_illegal, exp[63:0], exp[64]);
                else n_pass++;
            end
        end
        idle();
    endtask

    initial begin
        idle();
        csr_raddr = 0;
        test_reset();
        test_rw_ops();
        test_trap();
        test_mret();
        test_priority();
        test_reset_mid();
        test_counters();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
